eeprom_mirror_capture: RTL and testbench

- Sits directly downstream of the internal serial EEPROM emulation block and consumes its mirror stream (data, select, clock-running).
- Deserializes each write/erase mirror frame back into a 16-bit command word and an optional 16-bit data word.
- Queues completed frames in a small FIFO so the MCU-facing SPI bridge can persist save data to flash at its own pace.
- Reports malformed and dropped frames through sticky flags.

---
 rtl/eeprom_mirror_capture.sv | 205 ++++++++++++++++++++
 tb/tb_eeprom_mirror_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_mirror_capture.sv
// Rebuilds write/erase command frames from the EEPROM mirror stream and
// queues them in a first-word-fall-through FIFO for the flash bridge.
module eeprom_mirror_capture #(
  parameter int Depth = 4
) (
  input  logic                    SClk,
  input  logic                    Reset,
  input  logic                    SPIDo,
  input  logic                    SPISel,
  input  logic                    SPIClkRunning,
  input  logic                    FrameReady,
  input  logic                    ClearFlags,
  output logic                    FrameValid,
  output logic [15:0]             FrameCommand,
  output logic [15:0]             FrameData,
  output logic                    FrameLong,
  output logic [$clog2(Depth):0]  FrameCount,
  output logic                    FrameError,
  output logic                    FrameOverflow
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(Depth);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO   = AW'(0);
  localparam logic [5:0]    BITS_NONE  = 6'd0;
  localparam logic [5:0]    BITS_SHORT = 6'd16;
  localparam logic [5:0]    BITS_LONG  = 6'd32;
  localparam logic [5:0]    BITS_MAX   = 6'd33;

  logic          armed_r;
  logic          prev_sel_r;
  logic [31:0]   shift_r;
  logic [5:0]    bit_cnt_r;

  logic [15:0]   cmd_mem_r  [Depth];
  logic [15:0]   dat_mem_r  [Depth];
  logic          long_mem_r [Depth];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          valid_r;
  logic          error_r;
  logic          overflow_r;

  logic          frame_end_s;
  logic          sample_s;
  logic          good_s;
  logic          bad_s;
  logic          long_s;
  logic [15:0]   cmd_s;
  logic [15:0]   dat_s;
  logic          pop_s;
  logic          full_s;
  logic          push_s;
  logic          drop_s;
  logic [CW-1:0] count_nxt_s;

  // Frame boundary detection and decode of the bits collected so far.
  always_comb begin
    frame_end_s = armed_r & ~prev_sel_r & SPISel;
    sample_s    = armed_r & ~SPISel & SPIClkRunning;
    good_s      = 1'b0;
    bad_s       = 1'b0;
    long_s      = 1'b0;
    cmd_s       = 16'h0000;
    dat_s       = 16'h0000;
    case (bit_cnt_r)
      BITS_SHORT: begin
        good_s = frame_end_s;
        cmd_s  = shift_r[15:0];
      end
      BITS_LONG: begin
        good_s = frame_end_s;
        long_s = 1'b1;
        cmd_s  = shift_r[31:16];
        dat_s  = shift_r[15:0];
      end
      BITS_NONE: begin
        bad_s = 1'b0;
      end
      default: begin
        bad_s = frame_end_s;
      end
    endcase
  end

  // Queue control: a full queue still accepts a push when the head leaves on the same edge.
  always_comb begin
    pop_s  = valid_r & FrameReady;
    full_s = (count_r == DEPTH_C);
    push_s = good_s & (~full_s | pop_s);
    drop_s = good_s & full_s & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Arming: stay deaf until select has been seen idle, so a frame cut by reset is never half-captured.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      armed_r    <= 1'b0;
      prev_sel_r <= 1'b1;
    end else begin
      prev_sel_r <= SPISel;
      if (SPISel) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Deserializer: MSB-first shift with a saturating bit counter, cleared at every frame end.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      shift_r   <= 32'h0000_0000;
      bit_cnt_r <= BITS_NONE;
    end else if (frame_end_s) begin
      shift_r   <= 32'h0000_0000;
      bit_cnt_r <= BITS_NONE;
    end else if (sample_s) begin
      shift_r   <= {shift_r[30:0], SPIDo};
      bit_cnt_r <= (bit_cnt_r == BITS_MAX) ? BITS_MAX : (bit_cnt_r + 6'd1);
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Entry storage and pointers; storage clears on reset so the head reads zero.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        cmd_mem_r[i]  <= 16'h0000;
        dat_mem_r[i]  <= 16'h0000;
        long_mem_r[i] <= 1'b0;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        cmd_mem_r[wr_ptr_r]  <= cmd_s;
        dat_mem_r[wr_ptr_r]  <= dat_s;
        long_mem_r[wr_ptr_r] <= long_s;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy and the registered not-empty flag.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      count_r <= CNT_ZERO;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  // Sticky flags: a set event on the same edge as a clear wins.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      error_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (bad_s) begin
        error_r <= 1'b1;
      end else if (ClearFlags) begin
        error_r <= 1'b0;
      end else begin
        error_r <= error_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ClearFlags) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign FrameValid    = valid_r;
  assign FrameCount    = count_r;
  assign FrameCommand  = cmd_mem_r[rd_ptr_r];
  assign FrameData     = dat_mem_r[rd_ptr_r];
  assign FrameLong     = long_mem_r[rd_ptr_r];
  assign FrameError    = error_r;
  assign FrameOverflow = overflow_r;

endmodule

// File: tb/tb_eeprom_mirror_capture.sv
// Scoreboard bench for eeprom_mirror_capture: frames are modelled as they are
// driven and compared against the FIFO head as the consumer pops them.
module tb_eeprom_mirror_capture;

  logic        SClk = 1'b0;
  logic        Reset;
  logic        SPIDo;
  logic        SPISel;
  logic        SPIClkRunning;
  logic        FrameReady;
  logic        ClearFlags;
  logic        FrameValid;
  logic [15:0] FrameCommand;
  logic [15:0] FrameData;
  logic        FrameLong;
  logic [2:0]  FrameCount;
  logic        FrameError;
  logic        FrameOverflow;

  typedef struct packed {
    logic [15:0] cmd;
    logic [15:0] dat;
    logic        lng;
  } ent_t;

  ent_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;
  logic exp_ovf = 1'b0;

  eeprom_mirror_capture #(.Depth(4)) dut (
    .SClk(SClk), .Reset(Reset), .SPIDo(SPIDo), .SPISel(SPISel),
    .SPIClkRunning(SPIClkRunning), .FrameReady(FrameReady), .ClearFlags(ClearFlags),
    .FrameValid(FrameValid), .FrameCommand(FrameCommand), .FrameData(FrameData),
    .FrameLong(FrameLong), .FrameCount(FrameCount), .FrameError(FrameError),
    .FrameOverflow(FrameOverflow)
  );

  always #5 SClk = ~SClk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge SClk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_val({tag, ".valid"}, 32'(FrameValid), 32'(sb_q.size() != 0));
    check_val({tag, ".count"}, 32'(FrameCount), 32'(sb_q.size()));
    check_val({tag, ".err"},   32'(FrameError), 32'(exp_err));
    check_val({tag, ".ovf"},   32'(FrameOverflow), 32'(exp_ovf));
  endtask

  task automatic check_head(input string tag);
    ent_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, ".nonempty"}, 32'(FrameValid), 32'd0);
    end else begin
      e = sb_q[0];
      check_val({tag, ".valid"}, 32'(FrameValid), 32'd1);
      check_val({tag, ".cmd"},   32'(FrameCommand), 32'(e.cmd));
      check_val({tag, ".data"},  32'(FrameData), 32'(e.dat));
      check_val({tag, ".long"},  32'(FrameLong), 32'(e.lng));
    end
  endtask

  // Drives one frame of n bits; optional stall cycles with SPIClkRunning low carry junk data.
  task automatic send_frame(input string tag, input logic [31:0] val, input int n,
                            input logic rdy_end, input logic clr_end, input logic stalls);
    logic popped;
    logic good;
    ent_t e;
    SPISel = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (stalls && ($urandom_range(0, 1) == 1)) begin
        SPIClkRunning = 1'b0;
        SPIDo         = 1'($urandom_range(0, 1));
        tick();
      end
      SPIClkRunning = 1'b1;
      SPIDo         = val[n-1-i];
      tick();
    end
    SPIClkRunning = 1'b0;
    SPIDo         = 1'b0;
    SPISel        = 1'b1;
    FrameReady    = rdy_end;
    ClearFlags    = clr_end;
    popped        = 1'b0;
    if (rdy_end && sb_q.size() != 0) begin
      check_head({tag, ".pop"});
      popped = 1'b1;
    end
    tick();
    FrameReady = 1'b0;
    ClearFlags = 1'b0;
    if (popped) void'(sb_q.pop_front());
    good = (n == 16) || (n == 32);
    if (good) begin
      e.cmd = (n == 32) ? val[31:16] : val[15:0];
      e.dat = (n == 32) ? val[15:0] : 16'h0000;
      e.lng = (n == 32);
      if (sb_q.size() < 4) sb_q.push_back(e);
      else exp_ovf = 1'b1;
    end else if (clr_end) begin
      exp_ovf = 1'b0;
    end
    if (n != 0 && !good) exp_err = 1'b1;
    else if (clr_end) exp_err = 1'b0;
    if (good && clr_end && sb_q.size() < 4) exp_ovf = exp_ovf & ~clr_end;
    check_status(tag);
  endtask

  task automatic pop_one(input string tag);
    check_head(tag);
    FrameReady = 1'b1;
    tick();
    FrameReady = 1'b0;
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    check_status({tag, ".after"});
  endtask

  task automatic clear_flags();
    ClearFlags = 1'b1;
    tick();
    ClearFlags = 1'b0;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    check_status("clear");
  endtask

  initial begin
    Reset = 1'b1; SPIDo = 1'b0; SPISel = 1'b1; SPIClkRunning = 1'b0;
    FrameReady = 1'b0; ClearFlags = 1'b0;
    tick();
    tick();
    check_status("reset");
    check_val("reset.cmd",  32'(FrameCommand), 32'd0);
    check_val("reset.data", 32'(FrameData), 32'd0);
    check_val("reset.long", 32'(FrameLong), 32'd0);
    Reset = 1'b0;
    tick();

    send_frame("long1", 32'h0523_BEEF, 32, 1'b0, 1'b0, 1'b0);
    check_head("long1.head");
    pop_one("long1.pop");
    send_frame("erase", 32'h0000_0723, 16, 1'b0, 1'b0, 1'b1);
    check_head("erase.head");
    pop_one("erase.pop");

    send_frame("bad20", 32'h000A_5A5A, 20, 1'b0, 1'b0, 1'b0);
    clear_flags();
    send_frame("bad20clr", 32'h0003_1234, 20, 1'b0, 1'b1, 1'b0);
    clear_flags();

    for (int k = 1; k <= 5; k++) begin
      send_frame("ovf", {16'h1000 + 16'(k), 16'hA000 + 16'(k)}, 32, 1'b0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 4; k++) pop_one("ovf.drain");
    clear_flags();
    for (int k = 1; k <= 5; k++) begin
      send_frame("full_pop", {16'h2000 + 16'(k), 16'hB000 + 16'(k)}, 32, (k == 5), 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) pop_one("full_pop.drain");

    // Reset lands mid-frame; the tail of that frame must be ignored.
    SPISel = 1'b0;
    SPIClkRunning = 1'b1;
    for (int i = 0; i < 10; i++) begin SPIDo = 1'(i & 1); tick(); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    sb_q.delete();
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 21; i++) begin SPIDo = 1'(i & 1); tick(); end
    SPIClkRunning = 1'b0;
    SPISel = 1'b1;
    tick();
    check_status("rst_mid");
    send_frame("after_rst", 32'h0555_1357, 32, 1'b0, 1'b0, 1'b0);
    pop_one("after_rst.pop");

    send_frame("b2b_a", 32'h0A0B_C0DE, 32, 1'b0, 1'b0, 1'b0);
    send_frame("b2b_b", 32'h0C0D_F00D, 32, 1'b0, 1'b0, 1'b0);
    pop_one("b2b_a.pop");
    pop_one("b2b_b.pop");
    send_frame("toggle", 32'h0, 0, 1'b0, 1'b0, 1'b0);
    FrameReady = 1'b1;
    tick();
    FrameReady = 1'b0;
    check_status("empty_ready");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
